axi4lite_dpssram_bwsel: RTL and testbench

AXI4-Lite slave that maps one parametrised dual-port synchronous SRAM (width 8/16/32, power-of-two depth) into the bus address space, with per-byte-lane write enables on both ports. Port A belongs to the AXI side. Port B is a user port with read and write capability. Adds these over the fixed 8-bit, read-only-user variant:
- Out-of-range address decode with SLVERR.
- Fair arbitration between pending reads and writes.
- Port-collision rule.

---
 rtl/axi4lite_dpssram_bwsel_pkg.sv | 21 ++
 rtl/cheby_dpssram.sv | 66 ++++++
 rtl/axi4lite_dpssram_bwsel.sv | 207 ++++++++++++++++++++
 tb/tb_axi4lite_dpssram_bwsel.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_dpssram_bwsel_pkg.sv
// Shared definitions for the AXI4-Lite dual-port SRAM bridge: response codes,
// controller states and the byte-lane helper.
package axi4lite_dpssram_bwsel_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_READ_WAIT,
    ST_BRESP,
    ST_RRESP
  } state_t;

  function automatic int lane_count(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/cheby_dpssram.sv
// Dual-port synchronous SRAM with per-byte-lane write enables and registered,
// strobed read data. Reads during a same-address write return the old word.
module cheby_dpssram #(
  parameter int g_data_width = 32,
  parameter int g_size       = 1024,
  parameter int g_addr_width = 10,
  parameter bit g_dual_clock = 1'b0,
  parameter bit g_use_bwsel  = 1'b1
) (
  input  logic                      clk_a_i,
  input  logic                      clk_b_i,
  input  logic [g_addr_width-1:0]   addr_a_i,
  input  logic [g_data_width/8-1:0] bwsel_a_i,
  input  logic [g_data_width-1:0]   data_a_i,
  output logic [g_data_width-1:0]   data_a_o,
  input  logic                      rd_a_i,
  input  logic                      wr_a_i,
  input  logic [g_addr_width-1:0]   addr_b_i,
  input  logic [g_data_width/8-1:0] bwsel_b_i,
  input  logic [g_data_width-1:0]   data_b_i,
  output logic [g_data_width-1:0]   data_b_o,
  input  logic                      rd_b_i,
  input  logic                      wr_b_i
);

  localparam int L = g_data_width / 8;

  logic [g_data_width-1:0] mem [g_size];
  logic [L-1:0]            sel_a;
  logic [L-1:0]            sel_b;

  assign sel_a = g_use_bwsel ? bwsel_a_i : '1;
  assign sel_b = g_use_bwsel ? bwsel_b_i : '1;

  generate
    if (!g_dual_clock) begin : g_single
      logic unused_clk_b;
      assign unused_clk_b = clk_b_i;

      // Port B lanes are applied after port A, so B would win a same-word clash.
      always_ff @(posedge clk_a_i) begin
        for (int l = 0; l < L; l++) begin
          if (wr_a_i && sel_a[l]) mem[addr_a_i][l*8 +: 8] <= data_a_i[l*8 +: 8];
          if (wr_b_i && sel_b[l]) mem[addr_b_i][l*8 +: 8] <= data_b_i[l*8 +: 8];
        end
        if (rd_a_i) data_a_o <= mem[addr_a_i];
        if (rd_b_i) data_b_o <= mem[addr_b_i];
      end
    end else begin : g_dual
      always_ff @(posedge clk_a_i) begin
        for (int l = 0; l < L; l++) begin
          if (wr_a_i && sel_a[l]) mem[addr_a_i][l*8 +: 8] <= data_a_i[l*8 +: 8];
        end
        if (rd_a_i) data_a_o <= mem[addr_a_i];
      end

      always_ff @(posedge clk_b_i) begin
        for (int l = 0; l < L; l++) begin
          if (wr_b_i && sel_b[l]) mem[addr_b_i][l*8 +: 8] <= data_b_i[l*8 +: 8];
        end
        if (rd_b_i) data_b_o <= mem[addr_b_i];
      end
    end
  endgenerate

endmodule

// File: rtl/axi4lite_dpssram_bwsel.sv
// AXI4-Lite slave mapping a byte-lane dual-port SRAM; port B is a user
// read/write port that loses same-index write collisions to the AXI side.
//
// state        | meaning
// ST_IDLE      | waiting for a complete AW+W pair or an AR, arbitrating
// ST_WRITE     | port-A write strobe issued (suppressed if out of range)
// ST_READ      | port-A read strobe issued (suppressed if out of range)
// ST_READ_WAIT | RAM output valid, rdata/rresp captured on exit
// ST_BRESP     | bvalid held until bready
// ST_RRESP     | rvalid held until rready
module axi4lite_dpssram_bwsel
  import axi4lite_dpssram_bwsel_pkg::*;
#(
  parameter int g_data_width = 32,
  parameter int g_size       = 1024,
  parameter int g_addr_width = 20
) (
  input  logic                                  aclk,
  input  logic                                  areset_n,
  input  logic                                  awvalid,
  output logic                                  awready,
  input  logic [g_addr_width-1:2]               awaddr,
  input  logic [2:0]                            awprot,
  input  logic                                  wvalid,
  output logic                                  wready,
  input  logic [31:0]                           wdata,
  input  logic [3:0]                            wstrb,
  output logic                                  bvalid,
  input  logic                                  bready,
  output logic [1:0]                            bresp,
  input  logic                                  arvalid,
  output logic                                  arready,
  input  logic [g_addr_width-1:2]               araddr,
  input  logic [2:0]                            arprot,
  output logic                                  rvalid,
  input  logic                                  rready,
  output logic [31:0]                           rdata,
  output logic [1:0]                            rresp,
  input  logic [$clog2(g_size)-1:0]             mem_adr_i,
  input  logic                                  mem_rd_i,
  input  logic                                  mem_wr_i,
  input  logic [lane_count(g_data_width)-1:0]   mem_sel_i,
  input  logic [g_data_width-1:0]               mem_dat_i,
  output logic [g_data_width-1:0]               mem_dat_o
);

  localparam int AW = $clog2(g_size);
  localparam int L  = lane_count(g_data_width);

  logic                    aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic                    aw_oor_in, ar_oor_in;
  logic                    aw_held, w_held, ar_held;
  logic [AW-1:0]           aw_idx, ar_idx;
  logic                    aw_oor, ar_oor;
  logic [g_data_width-1:0] w_data;
  logic [L-1:0]            w_strb;
  state_t                  state, state_nxt;
  logic                    last_wr;
  logic                    grant_wr, grant_rd;
  logic                    wr_avail, rd_avail;
  logic [AW-1:0]           ram_addr_a;
  logic                    ram_wr_a, ram_rd_a, ram_wr_b;
  logic [g_data_width-1:0] ram_q_a;
  logic [31:0]             q_ext;
  logic                    unused_inputs;

  assign unused_inputs = ^{awprot, arprot, wdata, wstrb};

  generate
    if (g_addr_width > AW + 2) begin : g_decode
      assign aw_oor_in = |awaddr[g_addr_width-1:AW+2];
      assign ar_oor_in = |araddr[g_addr_width-1:AW+2];
    end else begin : g_no_decode
      assign aw_oor_in = 1'b0;
      assign ar_oor_in = 1'b0;
    end
  endgenerate

  assign awready = !aw_held;
  assign wready  = !w_held;
  assign arready = !ar_held;
  assign bvalid  = (state == ST_BRESP);
  assign rvalid  = (state == ST_RRESP);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;
  assign b_hs  = bvalid && bready;
  assign r_hs  = rvalid && rready;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      aw_held <= 1'b0;
      aw_idx  <= '0;
      aw_oor  <= 1'b0;
      w_held  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
      ar_held <= 1'b0;
      ar_idx  <= '0;
      ar_oor  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= awaddr[AW+1:2];
        aw_oor  <= aw_oor_in;
      end else if (b_hs) begin
        aw_held <= 1'b0;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= wdata[g_data_width-1:0];
        w_strb <= wstrb[L-1:0];
      end else if (b_hs) begin
        w_held <= 1'b0;
      end
      if (ar_hs) begin
        ar_held <= 1'b1;
        ar_idx  <= araddr[AW+1:2];
        ar_oor  <= ar_oor_in;
      end else if (r_hs) begin
        ar_held <= 1'b0;
      end
    end
  end

  // A handshake landing this edge counts, so service starts the cycle after it.
  assign wr_avail = (aw_held || aw_hs) && (w_held || w_hs);
  assign rd_avail = ar_held || ar_hs;

  always_comb begin
    state_nxt = state;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_avail && (!rd_avail || !last_wr)) begin
          grant_wr  = 1'b1;
          state_nxt = ST_WRITE;
        end else if (rd_avail) begin
          grant_rd  = 1'b1;
          state_nxt = ST_READ;
        end
      end
      ST_WRITE:     state_nxt = ST_BRESP;
      ST_READ:      state_nxt = ST_READ_WAIT;
      ST_READ_WAIT: state_nxt = ST_RRESP;
      ST_BRESP:     if (bready) state_nxt = ST_IDLE;
      ST_RRESP:     if (rready) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    q_ext = '0;
    q_ext[g_data_width-1:0] = ram_q_a;
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state   <= ST_IDLE;
      last_wr <= 1'b0;
      bresp   <= RESP_OKAY;
      rresp   <= RESP_OKAY;
      rdata   <= '0;
    end else begin
      state <= state_nxt;
      if (grant_wr)      last_wr <= 1'b1;
      else if (grant_rd) last_wr <= 1'b0;
      if (state == ST_WRITE) bresp <= aw_oor ? RESP_SLVERR : RESP_OKAY;
      if (state == ST_READ_WAIT) begin
        rresp <= ar_oor ? RESP_SLVERR : RESP_OKAY;
        rdata <= ar_oor ? '0 : q_ext;
      end
    end
  end

  assign ram_addr_a = (state == ST_WRITE) ? aw_idx : ar_idx;
  assign ram_wr_a   = (state == ST_WRITE) && !aw_oor;
  assign ram_rd_a   = (state == ST_READ) && !ar_oor;
  // The whole port-B write is dropped when port A writes any lane of the same word.
  assign ram_wr_b   = mem_wr_i && !(ram_wr_a && (|w_strb) && (aw_idx == mem_adr_i));

  cheby_dpssram #(
    .g_data_width (g_data_width),
    .g_size       (g_size),
    .g_addr_width (AW),
    .g_dual_clock (1'b0),
    .g_use_bwsel  (1'b1)
  ) u_ram (
    .clk_a_i   (aclk),
    .clk_b_i   (aclk),
    .addr_a_i  (ram_addr_a),
    .bwsel_a_i (w_strb),
    .data_a_i  (w_data),
    .data_a_o  (ram_q_a),
    .rd_a_i    (ram_rd_a),
    .wr_a_i    (ram_wr_a),
    .addr_b_i  (mem_adr_i),
    .bwsel_b_i (mem_sel_i),
    .data_b_i  (mem_dat_i),
    .data_b_o  (mem_dat_o),
    .rd_b_i    (mem_rd_i),
    .wr_b_i    (ram_wr_b)
  );

endmodule

// File: tb/tb_axi4lite_dpssram_bwsel.sv
// Bench for the AXI4-Lite SRAM bridge: a 32-bit and a 16-bit instance checked
// against a word-array model with byte-lane merge and range/arbitration rules.
module tb_axi4lite_dpssram_bwsel;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        areset_n;
  logic        awvalid [2], awready [2], wvalid [2], wready [2];
  logic        bvalid [2], bready [2], arvalid [2], arready [2];
  logic        rvalid [2], rready [2];
  logic [19:2] awaddr [2], araddr [2];
  logic [2:0]  awprot [2], arprot [2];
  logic [31:0] wdata [2], rdata [2];
  logic [3:0]  wstrb [2];
  logic [1:0]  bresp [2], rresp [2];
  logic [9:0]  mem_adr [2];
  logic        mem_rd [2], mem_wr [2];
  logic [3:0]  mem_sel [2];
  logic [31:0] mem_din [2];
  logic [31:0] mem_q0;
  logic [15:0] mem_q1;

  int total = 0;
  int bad   = 0;
  logic [31:0] model [2][16];

  axi4lite_dpssram_bwsel #(.g_data_width(32), .g_size(1024), .g_addr_width(20)) u_dut32 (
    .aclk(clk), .areset_n(areset_n),
    .awvalid(awvalid[0]), .awready(awready[0]), .awaddr(awaddr[0]), .awprot(awprot[0]),
    .wvalid(wvalid[0]), .wready(wready[0]), .wdata(wdata[0]), .wstrb(wstrb[0]),
    .bvalid(bvalid[0]), .bready(bready[0]), .bresp(bresp[0]),
    .arvalid(arvalid[0]), .arready(arready[0]), .araddr(araddr[0]), .arprot(arprot[0]),
    .rvalid(rvalid[0]), .rready(rready[0]), .rdata(rdata[0]), .rresp(rresp[0]),
    .mem_adr_i(mem_adr[0]), .mem_rd_i(mem_rd[0]), .mem_wr_i(mem_wr[0]),
    .mem_sel_i(mem_sel[0]), .mem_dat_i(mem_din[0]), .mem_dat_o(mem_q0)
  );

  axi4lite_dpssram_bwsel #(.g_data_width(16), .g_size(1024), .g_addr_width(20)) u_dut16 (
    .aclk(clk), .areset_n(areset_n),
    .awvalid(awvalid[1]), .awready(awready[1]), .awaddr(awaddr[1]), .awprot(awprot[1]),
    .wvalid(wvalid[1]), .wready(wready[1]), .wdata(wdata[1]), .wstrb(wstrb[1]),
    .bvalid(bvalid[1]), .bready(bready[1]), .bresp(bresp[1]),
    .arvalid(arvalid[1]), .arready(arready[1]), .araddr(araddr[1]), .arprot(arprot[1]),
    .rvalid(rvalid[1]), .rready(rready[1]), .rdata(rdata[1]), .rresp(rresp[1]),
    .mem_adr_i(mem_adr[1]), .mem_rd_i(mem_rd[1]), .mem_wr_i(mem_wr[1]),
    .mem_sel_i(mem_sel[1][1:0]), .mem_dat_i(mem_din[1][15:0]), .mem_dat_o(mem_q1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lanes(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  task automatic model_write(input int d, input int idx, input logic [31:0] data,
                             input logic [3:0] strb);
    for (int l = 0; l < lanes(d); l++)
      if (strb[l]) model[d][idx][l*8 +: 8] = data[l*8 +: 8];
  endtask

  task automatic wait_b(input int d, output int lat);
    lat = 1;
    while (bvalid[d] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_r(input int d, output int lat);
    lat = 1;
    while (rvalid[d] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic complete_b(input int d);
    bready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready[d] = 1'b0;
  endtask

  task automatic complete_r(input int d);
    rready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rready[d] = 1'b0;
  endtask

  task automatic axi_write(input int d, input logic [19:0] a, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp, output int lat);
    @(negedge clk);
    awaddr[d] = a[19:2]; wdata[d] = data; wstrb[d] = strb;
    awvalid[d] = 1'b1; wvalid[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    awvalid[d] = 1'b0; wvalid[d] = 1'b0;
    wait_b(d, lat);
    resp = bresp[d];
    complete_b(d);
  endtask

  task automatic axi_read(input int d, input logic [19:0] a, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    @(negedge clk);
    araddr[d] = a[19:2]; arvalid[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arvalid[d] = 1'b0;
    wait_r(d, lat);
    data = rdata[d];
    resp = rresp[d];
    complete_r(d);
  endtask

  task automatic pb_write(input int d, input int idx, input logic [31:0] data, input logic [3:0] sel);
    @(negedge clk);
    mem_adr[d] = 10'(idx); mem_din[d] = data; mem_sel[d] = sel; mem_wr[d] = 1'b1;
    @(negedge clk);
    mem_wr[d] = 1'b0;
  endtask

  task automatic pb_read(input int d, input int idx, output logic [31:0] data);
    @(negedge clk);
    mem_adr[d] = 10'(idx); mem_rd[d] = 1'b1;
    @(negedge clk);
    mem_rd[d] = 1'b0;
    data = (d == 0) ? mem_q0 : {16'h0, mem_q1};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] q, v, v2;
    int          lat;
    logic        seen;

    for (int d = 0; d < 2; d++) begin
      awvalid[d] = 0; wvalid[d] = 0; bready[d] = 0; arvalid[d] = 0; rready[d] = 0;
      awaddr[d] = '0; araddr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
      awprot[d] = 3'($urandom); arprot[d] = 3'($urandom);
      mem_adr[d] = '0; mem_rd[d] = 0; mem_wr[d] = 0; mem_sel[d] = '0; mem_din[d] = '0;
    end
    areset_n = 1'b1;
    #2 areset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_flags", {23'h0, awready[d], wready[d], arready[d], bvalid[d], rvalid[d],
                            bresp[d], rresp[d]}, 32'h1C0);
      check("reset_rdata", rdata[d], 32'h0);
    end
    areset_n = 1'b1;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) begin
        v = $urandom;
        axi_write(d, 20'(i * 4), v, 4'hF, resp, lat);
        check("init_bresp", {30'h0, resp}, 32'h0);
        model_write(d, i, v, 4'hF);
      end

    // Arbitration: fresh reset, write and read requested together -> write first.
    @(negedge clk) areset_n = 1'b0;
    @(negedge clk) areset_n = 1'b1;
    v = $urandom;
    @(negedge clk);
    awaddr[0] = 18'd1; wdata[0] = v; wstrb[0] = 4'hF; araddr[0] = 18'd2;
    awvalid[0] = 1; wvalid[0] = 1; arvalid[0] = 1;
    @(posedge clk);
    @(negedge clk);
    awvalid[0] = 0; wvalid[0] = 0; arvalid[0] = 0;
    model_write(0, 1, v, 4'hF);
    lat = 1;
    while (bvalid[0] !== 1'b1 && rvalid[0] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("arb1_bvalid_first", {31'h0, bvalid[0]}, 32'h1);
    check("arb1_no_rvalid", {31'h0, rvalid[0]}, 32'h0);
    check("arb1_latency", lat, 2);
    complete_b(0);
    wait_r(0, lat);
    check("arb1_rdata", rdata[0], model[0][2]);
    check("arb1_rresp", {30'h0, rresp[0]}, 32'h0);
    complete_r(0);

    // Last grant was a read; a lone write flips it, then a tie goes to the read.
    v = $urandom;
    axi_write(0, 20'h0C, v, 4'hF, resp, lat);
    model_write(0, 3, v, 4'hF);
    v2 = $urandom;
    @(negedge clk);
    awaddr[0] = 18'd5; wdata[0] = v2; wstrb[0] = 4'hF; araddr[0] = 18'd3;
    awvalid[0] = 1; wvalid[0] = 1; arvalid[0] = 1;
    @(posedge clk);
    @(negedge clk);
    awvalid[0] = 0; wvalid[0] = 0; arvalid[0] = 0;
    lat = 1;
    while (bvalid[0] !== 1'b1 && rvalid[0] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("arb2_rvalid_first", {31'h0, rvalid[0]}, 32'h1);
    check("arb2_no_bvalid", {31'h0, bvalid[0]}, 32'h0);
    check("arb2_rdata", rdata[0], model[0][3]);
    complete_r(0);
    wait_b(0, lat);
    check("arb2_bvalid_after", {31'h0, bvalid[0]}, 32'h1);
    complete_b(0);
    model_write(0, 5, v2, 4'hF);
    axi_read(0, 20'h14, q, resp, lat);
    check("arb2_write_landed", q, model[0][5]);

    // Byte-lane merge and handshake latencies.
    axi_write(0, 20'h10, 32'hFFFF_FFFF, 4'hF, resp, lat);
    model_write(0, 4, 32'hFFFF_FFFF, 4'hF);
    axi_write(0, 20'h10, 32'hA5A5_1234, 4'b0101, resp, lat);
    model_write(0, 4, 32'hA5A5_1234, 4'b0101);
    check("lane_bresp", {30'h0, resp}, 32'h0);
    check("write_latency", lat, 2);
    axi_read(0, 20'h10, q, resp, lat);
    check("lane_rdata", q, 32'hFFA5_FF34);
    check("lane_model", q, model[0][4]);
    check("lane_rresp", {30'h0, resp}, 32'h0);
    check("read_latency", lat, 3);

    // Zero strobes write nothing but still answer OKAY.
    axi_write(0, 20'h1C, $urandom, 4'h0, resp, lat);
    check("nostrb_bresp", {30'h0, resp}, 32'h0);
    axi_read(0, 20'h1C, q, resp, lat);
    check("nostrb_rdata", q, model[0][7]);

    // Out-of-range index aliasing word 0.
    axi_write(0, 20'h1000, 32'hDEAD_BEEF, 4'hF, resp, lat);
    check("oor_bresp", {30'h0, resp}, 32'h2);
    axi_read(0, 20'h1000, q, resp, lat);
    check("oor_rdata", q, 32'h0);
    check("oor_rresp", {30'h0, resp}, 32'h2);
    axi_read(0, 20'h0, q, resp, lat);
    check("oor_ram_unchanged", q, model[0][0]);

    // AW held, W delayed five cycles.
    v = $urandom;
    @(negedge clk);
    awaddr[0] = 18'd6; awvalid[0] = 1;
    @(posedge clk);
    @(negedge clk);
    awvalid[0] = 0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("dly_awready", {31'h0, awready[0]}, 32'h0);
      seen |= bvalid[0];
      @(negedge clk);
    end
    check("dly_no_bvalid", {31'h0, seen}, 32'h0);
    pb_read(0, 6, q);
    check("dly_no_early_write", q, model[0][6]);
    wdata[0] = v; wstrb[0] = 4'hF; wvalid[0] = 1;
    @(posedge clk);
    @(negedge clk);
    wvalid[0] = 0;
    wait_b(0, lat);
    check("dly_b_latency", lat, 2);
    complete_b(0);
    seen = 1'b0;
    repeat (4) begin
      seen |= bvalid[0];
      @(negedge clk);
    end
    check("dly_single_bvalid", {31'h0, seen}, 32'h0);
    model_write(0, 6, v, 4'hF);
    axi_read(0, 20'h18, q, resp, lat);
    check("dly_rdata", q, model[0][6]);

    // 16-bit instance: port-B write collides with the AXI write to index 8.
    @(negedge clk);
    awaddr[1] = 18'd8; wdata[1] = 32'h0000_1111; wstrb[1] = 4'b0011;
    awvalid[1] = 1; wvalid[1] = 1;
    @(posedge clk);
    @(negedge clk);
    awvalid[1] = 0; wvalid[1] = 0;
    mem_adr[1] = 10'd8; mem_din[1] = 32'h0000_BEEF; mem_sel[1] = 4'b0011; mem_wr[1] = 1;
    @(negedge clk);
    mem_wr[1] = 0;
    wait_b(1, lat);
    complete_b(1);
    model_write(1, 8, 32'h1111, 4'b0011);
    axi_read(1, 20'h20, q, resp, lat);
    check("coll_axi_rdata", q, 32'h0000_1111);
    pb_read(1, 8, q);
    check("coll_portb_rdata", q, 32'h0000_1111);
    pb_write(1, 9, 32'h0000_BEEF, 4'b0010);
    model_write(1, 9, 32'hBEEF, 4'b0010);
    axi_read(1, 20'h24, q, resp, lat);
    check("portb_write_rdata", q, model[1][9]);
    axi_write(1, 20'h28, 32'hFFFF_FFFF, 4'b1100, resp, lat);
    axi_read(1, 20'h28, q, resp, lat);
    check("w16_upper_strb_ignored", q, model[1][10]);

    // Reset while the read sits in READ_WAIT.
    @(negedge clk);
    araddr[0] = 18'd2; arvalid[0] = 1;
    @(posedge clk);
    @(negedge clk);
    arvalid[0] = 0;
    @(negedge clk);
    #1 areset_n = 1'b0;
    #1;
    check("rst_mid_flags", {23'h0, awready[0], wready[0], arready[0], bvalid[0], rvalid[0],
                            bresp[0], rresp[0]}, 32'h1C0);
    check("rst_mid_rdata", rdata[0], 32'h0);
    @(negedge clk) areset_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      seen |= rvalid[0];
      @(negedge clk);
    end
    check("rst_mid_no_rvalid", {31'h0, seen}, 32'h0);
    axi_read(0, 20'h08, q, resp, lat);
    check("rst_after_rdata", q, model[0][2]);
    check("rst_after_lat", lat, 3);

    // Randomized mix against the model.
    for (int n = 0; n < 80; n++) begin
      int d, idx, op;
      logic oor;
      logic [7:0] hi;
      logic [19:0] a;
      logic [3:0] strb;
      d   = int'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 15));
      oor = ($urandom_range(0, 5) == 0);
      hi  = oor ? 8'($urandom_range(1, 255)) : 8'h0;
      a   = {hi, 10'(idx), 2'b00};
      op  = int'($urandom_range(0, 3));
      v   = $urandom;
      strb = 4'($urandom_range(0, 15));
      case (op)
        0: begin
          axi_write(d, a, v, strb, resp, lat);
          check("rnd_bresp", {30'h0, resp}, oor ? 32'h2 : 32'h0);
          if (!oor) model_write(d, idx, v, strb);
        end
        1: begin
          axi_read(d, a, q, resp, lat);
          check("rnd_rdata", q, oor ? 32'h0 : model[d][idx]);
          check("rnd_rresp", {30'h0, resp}, oor ? 32'h2 : 32'h0);
        end
        2: begin
          pb_read(d, idx, q);
          check("rnd_pb_rdata", q, model[d][idx]);
        end
        default: begin
          pb_write(d, idx, v, strb);
          model_write(d, idx, v, strb);
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
